cc_cond: RTL
============

Name: cc_cond

Overview:
- Consumer end of the ALU flag interface. It captures the 3-bit condition code {ZF,SF,OF} that the ALU produces for OPq instructions.
- Holds the captured flags for one cycle as a pending update, then commits them to the architectural CC register unless an exception suppresses them.
- Evaluates the Y86-64 jXX/cmovXX condition (Cnd) from the most recent non-suppressed flags.
- Sits between the ALU and the fetch/writeback control logic.

Parameters:
- CC_RESET, 3'b100, architectural CC value after reset (ZF=1, SF=0, OF=0).
- CNT_W, 16, width of the committed-update counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- set_cc  in  1  ALU flags in CC_in are valid and must be captured (OPq in execute).
- CC_in  in  3  flags from the ALU: [2]=ZF, [1]=SF, [0]=OF.
- stall  in  1  freeze capture and commit this cycle.
- suppress  in  1  exception raised; discard the pending update.
- icode  in  4  current instruction code.
- ifun  in  4  current function code.
- CC_out  out  3  architectural (committed) CC register.
- Cnd  out  1  condition result for the current icode/ifun.
- cond_err  out  1  invalid condition function for a conditional instruction.
- pend_valid  out  1  a captured update is awaiting commit.
- upd_count  out  CNT_W  number of committed CC updates, saturating.

Behaviour:
- Reset (reset=1 at an edge):
  - cc_reg <= CC_RESET.
  - pend_valid <= 0 and pend_cc <= 0.
  - upd_count <= 0.
  - Reset overrides all other inputs, including in-flight pending updates.
- Effective flags:
  - eff_cc = (pend_valid & ~suppress) ? pend_cc : cc_reg.
  - This forwards the flags so a jXX/cmov immediately after an OPq sees the new flags with zero bubbles.
- Condition evaluation (combinational from eff_cc, with Z=ZF, S=SF, O=OF):
  - ifun 0: 1
  - ifun 1 (le): (S^O)|Z
  - ifun 2 (l): S^O
  - ifun 3 (e): Z
  - ifun 4 (ne): ~Z
  - ifun 5 (ge): ~(S^O)
  - ifun 6 (g): ~(S^O)&~Z
- Output qualification:
  - Cnd is driven by the table above only when icode==4'h2 (rrmov/cmovXX) or icode==4'h7 (jXX); otherwise Cnd=0.
  - cond_err=1 iff icode is in {2,7} and ifun>6; in that case Cnd=0.
  - Neither output depends on stall.
- Per-edge update, in priority order when reset=0:
  1. suppress=1: pend_valid <= 0. No commit. A new set_cc in the same cycle is also dropped, because the faulting instruction's successors must not set flags.
  2. else if stall=1: all state holds; set_cc is ignored.
  3. else:
     - If pend_valid, cc_reg <= pend_cc and upd_count increments, saturating at 2^CNT_W-1.
     - If set_cc, pend_cc <= CC_in and pend_valid <= 1; otherwise pend_valid <= 0.
     - Back-to-back set_cc commits the older pending value and captures the newer one in the same cycle.
- Latency:
  - CC_in reaches eff_cc/Cnd 1 cycle after capture (via pend_cc).
  - CC_in reaches CC_out 2 edges after set_cc if not stalled or suppressed.
- Outputs:
  - CC_out reflects only committed state; speculative flags never appear on it.
  - pend_valid is a direct register output.
- Stall with pending data:
  - The update stays pending and eff_cc keeps forwarding it.
  - A suppress arriving during the stall discards it.

Test Plan:
- Reset: hold reset 2 cycles → CC_out=3'b100, pend_valid=0, upd_count=0. With icode=7, ifun=3, Cnd=1. With ifun=4, Cnd=0.
- Single update plus forwarding: set_cc=1, CC_in=3'b010 for one cycle.
  - Next cycle: pend_valid=1; with icode=7, ifun=2 (l), Cnd=1; CC_out still 3'b100.
  - Following cycle: CC_out=3'b010, upd_count=1, pend_valid=0.
- Back-to-back: set_cc with 3'b001 then 3'b100 on consecutive cycles.
  - Cycle 2: eff_cc=3'b100, so ifun=1 (le) gives Cnd=1.
  - CC_out goes 3'b001 then 3'b100; upd_count=2.
- Suppress: capture 3'b000, then assert suppress the next cycle (also with set_cc=1, CC_in=3'b011).
  - pend_valid=0 and CC_out unchanged at 3'b100.
  - Cnd for ifun=3 is evaluated from cc_reg, giving 1.
- Stall: capture 3'b010, then stall 3 cycles.
  - pend_valid stays 1 and CC_out holds its old value; set_cc during the stall is ignored.
  - After the stall is released, CC_out=3'b010 one edge later.
- Decode edges and reset mid-op:
  - icode=7, ifun=9 → Cnd=0, cond_err=1.
  - icode=6, ifun=1 → Cnd=0, cond_err=0.
  - reset asserted while pend_valid=1 → CC_out=3'b100 and the pending update is lost.
  - Preload upd_count to all-ones via repeated updates with CNT_W=2 → count saturates at 3.

Source files
------------

// File: rtl/cc_cond_if.sv
// Flag-path bundle between the ALU/pipeline control and the condition-code unit.
// Latency: n/a (wiring only).
// Backpressure: n/a; stall and suppress are carried as plain control levels.
interface cc_cond_if #(
    parameter int CNT_W = 16
);
    logic             set_cc;
    logic [2:0]       CC_in;
    logic             stall;
    logic             suppress;
    logic [3:0]       icode;
    logic [3:0]       ifun;
    logic [2:0]       CC_out;
    logic             Cnd;
    logic             cond_err;
    logic             pend_valid;
    logic [CNT_W-1:0] upd_count;

    // Pipeline control side: drives flags and instruction fields, reads results.
    modport master (
        output set_cc, CC_in, stall, suppress, icode, ifun,
        input  CC_out, Cnd, cond_err, pend_valid, upd_count
    );

    // Condition-code unit side.
    modport slave (
        input  set_cc, CC_in, stall, suppress, icode, ifun,
        output CC_out, Cnd, cond_err, pend_valid, upd_count
    );
endinterface

// File: rtl/cc_cond.sv
// Captures ALU {ZF,SF,OF}, holds them one cycle as a pending update, commits to CC; evaluates jXX/cmovXX Cnd.
// Latency: CC_in visible on Cnd 1 cycle after capture (forwarded), on CC_out 2 edges after set_cc.
// Backpressure: stall freezes capture and commit; suppress discards the pending update and any new capture.
module cc_cond #(
    parameter logic [2:0] CC_RESET = 3'b100,
    parameter int         CNT_W    = 16
) (
    input  logic    clk,
    input  logic    reset,
    cc_cond_if.slave cc
);
    localparam logic [3:0] IC_CMOV = 4'h2;
    localparam logic [3:0] IC_JXX  = 4'h7;

    logic [2:0]       cc_reg;
    logic [2:0]       pend_cc;
    logic             pend_vld;
    logic [CNT_W-1:0] cnt_q;

    logic [2:0]       eff_cc;
    logic             cond_instr;
    logic             cnd_raw;
    logic             less;

    // Forward the pending flags unless this cycle's exception is about to discard them.
    assign eff_cc     = (pend_vld && !cc.suppress) ? pend_cc : cc_reg;
    assign cond_instr = (cc.icode == IC_CMOV) || (cc.icode == IC_JXX);
    assign less       = eff_cc[1] ^ eff_cc[0];

    // Y86-64 condition table over the effective flags; undefined functions yield 0.
    always_comb begin
        cnd_raw = 1'b0;
        case (cc.ifun)
            4'd0:    cnd_raw = 1'b1;
            4'd1:    cnd_raw = less | eff_cc[2];
            4'd2:    cnd_raw = less;
            4'd3:    cnd_raw = eff_cc[2];
            4'd4:    cnd_raw = ~eff_cc[2];
            4'd5:    cnd_raw = ~less;
            4'd6:    cnd_raw = ~less & ~eff_cc[2];
            default: cnd_raw = 1'b0;
        endcase
    end

    // Pending capture, commit into the architectural register and saturating commit count.
    always_ff @(posedge clk) begin
        if (reset) begin
            cc_reg   <= CC_RESET;
            pend_cc  <= 3'b000;
            pend_vld <= 1'b0;
            cnt_q    <= '0;
        end else if (cc.suppress) begin
            // Successors of a faulting instruction must not set flags, so a same-cycle set_cc is dropped too.
            pend_vld <= 1'b0;
        end else if (!cc.stall) begin
            if (pend_vld) begin
                cc_reg <= pend_cc;
                if (cnt_q != {CNT_W{1'b1}}) begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end
            pend_vld <= cc.set_cc;
            if (cc.set_cc) begin
                pend_cc <= cc.CC_in;
            end
        end
    end

    assign cc.CC_out     = cc_reg;
    assign cc.Cnd        = cond_instr && (cc.ifun <= 4'd6) && cnd_raw;
    assign cc.cond_err   = cond_instr && (cc.ifun > 4'd6);
    assign cc.pend_valid = pend_vld;
    assign cc.upd_count  = cnt_q;
endmodule
